ex_mem_stage: RTL and testbench

EX_MEM_STAGE -- requirements
Module: ex_mem_stage

---
 rtl/ex_mem_pkg.sv | 27 ++
 rtl/ex_mem_if.sv | 42 ++++
 rtl/ex_mem_entry.sv | 17 +
 rtl/ex_mem_stage.sv | 102 ++++++++++
 tb/tb_ex_mem_stage.sv | 335 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ex_mem_pkg.sv
// Shared definitions for the EX/MEM pipeline stage: control-bundle layout,
// default widths and the occupancy state encoding.
package ex_mem_pkg;

  localparam int CTRL_W_DEF = 7;

  // Control bundle bit positions
  localparam int CTRL_REGWRITE    = 6;
  localparam int CTRL_MEMTOREG    = 5;
  localparam int CTRL_BRANCH      = 4;
  localparam int CTRL_MEMREAD_HI  = 3;
  localparam int CTRL_MEMREAD_LO  = 2;
  localparam int CTRL_MEMWRITE_HI = 1;
  localparam int CTRL_MEMWRITE_LO = 0;

  // State value doubles as the number of held entries
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_e;

  function automatic logic [1:0] occ_of(input state_e s);
    return logic'(s[1]) ? 2'd2 : {1'b0, s[0]};
  endfunction

endpackage

// File: rtl/ex_mem_if.sv
// Upstream (EX) and downstream (MEM) handshake bundle for ex_mem_stage.
// master = environment driving the stage, slave = the stage itself.
interface ex_mem_if
  import ex_mem_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5,
  parameter int CTRL_W = CTRL_W_DEF
);
  logic              InValid;
  logic              InReady;
  logic [CTRL_W-1:0] InCtrl;
  logic [DATA_W-1:0] InALUResult;
  logic [DATA_W-1:0] InStoreData;
  logic [DATA_W-1:0] InPCAddResult;
  logic [REG_W-1:0]  InWriteReg;
  logic              InZero;

  logic              OutValid;
  logic              OutReady;
  logic [CTRL_W-1:0] OutCtrl;
  logic [DATA_W-1:0] OutALUResult;
  logic [DATA_W-1:0] OutStoreData;
  logic [DATA_W-1:0] OutPCAddResult;
  logic [REG_W-1:0]  OutWriteReg;
  logic              OutZero;

  modport master (
    output InValid, InCtrl, InALUResult, InStoreData, InPCAddResult, InWriteReg, InZero,
    input  InReady,
    input  OutValid, OutCtrl, OutALUResult, OutStoreData, OutPCAddResult, OutWriteReg, OutZero,
    output OutReady
  );

  modport slave (
    input  InValid, InCtrl, InALUResult, InStoreData, InPCAddResult, InWriteReg, InZero,
    output InReady,
    output OutValid, OutCtrl, OutALUResult, OutStoreData, OutPCAddResult, OutWriteReg, OutZero,
    input  OutReady
  );

endinterface

// File: rtl/ex_mem_entry.sv
// One payload register of the EX/MEM stage: load enable, asynchronous clear.
module ex_mem_entry #(
  parameter int W = 8
) (
  input  logic         Clock,
  input  logic         Reset,
  input  logic         load,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset)    q <= '0;
    else if (load) q <= d;
  end

endmodule

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register with valid/ready handshake. With EX_MEM_SKID_EN
// defined a skid entry is added so InReady is registered; otherwise a single entry.
module ex_mem_stage
  import ex_mem_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5,
  parameter int CTRL_W = CTRL_W_DEF
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       Flush,
  output logic [1:0] Occupancy,
  ex_mem_if.slave    bus
);

  localparam int PL_W = CTRL_W + 3 * DATA_W + REG_W + 1;

  state_e            state_q, state_d;
  logic              acc, drn, main_ld;
  logic [PL_W-1:0]   in_pl, main_d, main_q;
  logic [CTRL_W-1:0] main_ctrl;

  assign acc   = bus.InValid && bus.InReady;
  assign drn   = bus.OutValid && bus.OutReady;
  assign in_pl = {bus.InCtrl, bus.InALUResult, bus.InStoreData, bus.InPCAddResult,
                  bus.InWriteReg, bus.InZero};

  ex_mem_entry #(.W(PL_W)) u_main (
    .Clock (Clock),
    .Reset (Reset),
    .load  (main_ld),
    .d     (main_d),
    .q     (main_q)
  );

`ifdef EX_MEM_SKID_EN
  logic [PL_W-1:0] skid_q;
  logic            skid_ld;
  logic            in_ready_q;

  ex_mem_entry #(.W(PL_W)) u_skid (
    .Clock (Clock),
    .Reset (Reset),
    .load  (skid_ld),
    .d     (in_pl),
    .q     (skid_q)
  );

  // Ready is taken from the next state so it never depends on OutReady this cycle
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) in_ready_q <= 1'b1;
    else        in_ready_q <= (state_d != ST_FULL);
  end

  assign bus.InReady = in_ready_q;
  assign main_d      = (state_q == ST_FULL) ? skid_q : in_pl;
`else
  assign bus.InReady = bus.OutReady || !bus.OutValid;
  assign main_d      = in_pl;
`endif

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) state_q <= ST_EMPTY;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_EMPTY: if (acc) state_d = ST_ONE;
`ifdef EX_MEM_SKID_EN
      ST_ONE: begin
        if (acc && !drn)      state_d = ST_FULL;
        else if (!acc && drn) state_d = ST_EMPTY;
      end
`else
      ST_ONE: if (!acc && drn) state_d = ST_EMPTY;
`endif
      ST_FULL:  if (drn) state_d = ST_ONE;
      default:  state_d = ST_EMPTY;
    endcase
    if (Flush) state_d = ST_EMPTY;
  end

  // Loads are suppressed on Flush so data outputs keep their last value
  always_comb begin
    bus.OutValid = (state_q != ST_EMPTY);
    Occupancy    = occ_of(state_q);
    main_ld      = !Flush && (((state_q == ST_EMPTY) && acc) ||
                              ((state_q == ST_ONE) && acc && drn) ||
                              ((state_q == ST_FULL) && drn));
`ifdef EX_MEM_SKID_EN
    skid_ld      = !Flush && (state_q == ST_ONE) && acc && !drn;
`endif
  end

  assign {main_ctrl, bus.OutALUResult, bus.OutStoreData, bus.OutPCAddResult,
          bus.OutWriteReg, bus.OutZero} = main_q;
  assign bus.OutCtrl = bus.OutValid ? main_ctrl : '0;

endmodule

// File: tb/tb_ex_mem_stage.sv
// Self-checking bench for ex_mem_stage: directed table, hand sequences for
// flush/reset/skid corners, and a randomized run against a queue model.
module tb_ex_mem_stage;
  import ex_mem_pkg::*;

  localparam int DATA_W = 32;
  localparam int REG_W  = 5;
  localparam int CTRL_W = 7;

  typedef struct packed {
    logic [6:0]  ctrl;
    logic [31:0] alu;
    logic [31:0] sd;
    logic [31:0] pc;
    logic [4:0]  wr;
    logic        z;
  } pl_t;

  typedef struct {
    logic        iv;
    logic [31:0] alu;
    logic        ordy;
    logic        ev;
    logic [31:0] ealu;
    logic [1:0]  eocc;
    logic        erdy;
    logic [6:0]  ectrl;
  } vec_t;

  logic       Clock = 1'b0;
  logic       Reset;
  logic       Flush;
  logic [1:0] Occupancy;

  ex_mem_if #(.DATA_W(DATA_W), .REG_W(REG_W), .CTRL_W(CTRL_W)) bus ();

  ex_mem_stage #(.DATA_W(DATA_W), .REG_W(REG_W), .CTRL_W(CTRL_W)) dut (
    .Clock     (Clock),
    .Reset     (Reset),
    .Flush     (Flush),
    .Occupancy (Occupancy),
    .bus       (bus)
  );

  always #5 Clock = ~Clock;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic pl_t mk(input logic [31:0] alu, input logic [6:0] ctrl);
    pl_t p;
    p.ctrl = ctrl;
    p.alu  = alu;
    p.sd   = ~alu;
    p.pc   = alu + 32'd4;
    p.wr   = alu[4:0];
    p.z    = (alu == 32'd0);
    return p;
  endfunction

  task automatic drive(input logic v, input pl_t p);
    bus.InValid       = v;
    bus.InCtrl        = p.ctrl;
    bus.InALUResult   = p.alu;
    bus.InStoreData   = p.sd;
    bus.InPCAddResult = p.pc;
    bus.InWriteReg    = p.wr;
    bus.InZero        = p.z;
  endtask

  task automatic next_cycle();
    @(posedge Clock);
    #1;
  endtask

  task automatic do_reset();
    Reset = 1'b0;
    Flush = 1'b0;
    bus.OutReady = 1'b0;
    drive(1'b0, mk(32'd0, 7'd0));
    @(posedge Clock);
    @(negedge Clock);
    check("rst_valid", 64'(bus.OutValid), 64'(0));
    check("rst_ready", 64'(bus.InReady), 64'(1));
    check("rst_occ", 64'(Occupancy), 64'(0));
    check("rst_ctrl", 64'(bus.OutCtrl), 64'(0));
    check("rst_alu", 64'(bus.OutALUResult), 64'(0));
    Reset = 1'b1;
    next_cycle();
  endtask

  vec_t tbl[10];
  pl_t  q[$];

  initial begin
    pl_t  p;
    logic iv, ordy, fl, mrdy, acc, drn;

    do_reset();

    // Single transaction latency
    bus.OutReady = 1'b1;
    drive(1'b1, mk(32'h0000_0010, 7'd0));
    @(negedge Clock);
    check("lat_valid0", 64'(bus.OutValid), 64'(0));
    check("lat_ready0", 64'(bus.InReady), 64'(1));
    next_cycle();
    drive(1'b0, mk(32'd0, 7'd0));
    @(negedge Clock);
    check("lat_valid1", 64'(bus.OutValid), 64'(1));
    check("lat_alu1", 64'(bus.OutALUResult), 64'h10);
    check("lat_occ1", 64'(Occupancy), 64'(1));
    next_cycle();

    // Streaming table: payloads 1..8 with OutReady held high
    for (int i = 0; i < 8; i++) begin
      tbl[i].iv    = 1'b1;
      tbl[i].alu   = 32'(i + 1);
      tbl[i].ordy  = 1'b1;
      tbl[i].ev    = (i != 0);
      tbl[i].ealu  = 32'(i);
      tbl[i].eocc  = (i != 0) ? 2'd1 : 2'd0;
      tbl[i].erdy  = 1'b1;
      tbl[i].ectrl = (i != 0) ? 7'h40 : 7'h00;
    end
    tbl[8] = '{1'b0, 32'd0, 1'b1, 1'b1, 32'd8, 2'd1, 1'b1, 7'h40};
    tbl[9] = '{1'b0, 32'd0, 1'b1, 1'b0, 32'd0, 2'd0, 1'b1, 7'h00};
    for (int i = 0; i < 10; i++) begin
      drive(tbl[i].iv, mk(tbl[i].alu, 7'h40));
      bus.OutReady = tbl[i].ordy;
      @(negedge Clock);
      check($sformatf("tbl%0d_valid", i), 64'(bus.OutValid), 64'(tbl[i].ev));
      check($sformatf("tbl%0d_occ", i), 64'(Occupancy), 64'(tbl[i].eocc));
      check($sformatf("tbl%0d_ready", i), 64'(bus.InReady), 64'(tbl[i].erdy));
      check($sformatf("tbl%0d_ctrl", i), 64'(bus.OutCtrl), 64'(tbl[i].ectrl));
      if (tbl[i].ev)
        check($sformatf("tbl%0d_alu", i), 64'(bus.OutALUResult), 64'(tbl[i].ealu));
      next_cycle();
    end

    // Backpressure with three payloads offered
    do_reset();
`ifdef EX_MEM_SKID_EN
    drive(1'b1, mk(32'd1, 7'h40));
    @(negedge Clock);
    check("bp_ready0", 64'(bus.InReady), 64'(1));
    next_cycle();
    drive(1'b1, mk(32'd2, 7'h40));
    @(negedge Clock);
    check("bp_occ1", 64'(Occupancy), 64'(1));
    check("bp_ready1", 64'(bus.InReady), 64'(1));
    next_cycle();
    drive(1'b1, mk(32'd3, 7'h40));
    @(negedge Clock);
    check("bp_occ2", 64'(Occupancy), 64'(2));
    check("bp_ready2", 64'(bus.InReady), 64'(0));
    check("bp_alu2", 64'(bus.OutALUResult), 64'(1));
    next_cycle();
    @(negedge Clock);
    check("bp_hold_occ", 64'(Occupancy), 64'(2));
    check("bp_hold_alu", 64'(bus.OutALUResult), 64'(1));
    next_cycle();
    bus.OutReady = 1'b1;
    @(negedge Clock);
    check("bp_out1", 64'(bus.OutALUResult), 64'(1));
    next_cycle();
    @(negedge Clock);
    check("bp_out2", 64'(bus.OutALUResult), 64'(2));
    check("bp_ready3", 64'(bus.InReady), 64'(1));
    check("bp_occ3", 64'(Occupancy), 64'(1));
    next_cycle();
    drive(1'b0, mk(32'd0, 7'h0));
    @(negedge Clock);
    check("bp_out3", 64'(bus.OutALUResult), 64'(3));
    next_cycle();
    @(negedge Clock);
    check("bp_empty", 64'(bus.OutValid), 64'(0));
    next_cycle();
`else
    drive(1'b1, mk(32'd1, 7'h40));
    next_cycle();
    drive(1'b1, mk(32'd2, 7'h40));
    @(negedge Clock);
    check("bp_occ1", 64'(Occupancy), 64'(1));
    check("bp_ready1", 64'(bus.InReady), 64'(0));
    check("bp_alu1", 64'(bus.OutALUResult), 64'(1));
    next_cycle();
    bus.OutReady = 1'b1;
    @(negedge Clock);
    check("bp_ready2", 64'(bus.InReady), 64'(1));
    check("bp_out1", 64'(bus.OutALUResult), 64'(1));
    next_cycle();
    drive(1'b1, mk(32'd3, 7'h40));
    @(negedge Clock);
    check("bp_out2", 64'(bus.OutALUResult), 64'(2));
    next_cycle();
    drive(1'b0, mk(32'd0, 7'h0));
    @(negedge Clock);
    check("bp_out3", 64'(bus.OutALUResult), 64'(3));
    next_cycle();
    @(negedge Clock);
    check("bp_empty", 64'(bus.OutValid), 64'(0));
    next_cycle();
`endif

    // Flush while holding entries, with a concurrent accept offered
    do_reset();
    drive(1'b1, mk(32'hA, 7'h40));
    next_cycle();
    drive(1'b1, mk(32'hB, 7'h40));
    next_cycle();
    drive(1'b0, mk(32'd0, 7'h0));
    @(negedge Clock);
`ifdef EX_MEM_SKID_EN
    check("fl_occ_pre", 64'(Occupancy), 64'(2));
`else
    check("fl_occ_pre", 64'(Occupancy), 64'(1));
`endif
    check("fl_ctrl_pre", 64'(bus.OutCtrl), 64'h40);
    next_cycle();
    Flush = 1'b1;
    bus.OutReady = 1'b1;
    drive(1'b1, mk(32'hC, 7'h40));
    next_cycle();
    Flush = 1'b0;
    drive(1'b0, mk(32'd0, 7'h0));
    @(negedge Clock);
    check("fl_valid", 64'(bus.OutValid), 64'(0));
    check("fl_ctrl", 64'(bus.OutCtrl), 64'(0));
    check("fl_occ", 64'(Occupancy), 64'(0));
    check("fl_ready", 64'(bus.InReady), 64'(1));
    check("fl_alu_hold", 64'(bus.OutALUResult), 64'hA);
    next_cycle();
    @(negedge Clock);
    check("fl_still_empty", 64'(bus.OutValid), 64'(0));
    next_cycle();

    // Asynchronous reset between clock edges while holding entries
    do_reset();
    drive(1'b1, mk(32'h77, 7'h40));
    next_cycle();
    drive(1'b1, mk(32'h78, 7'h40));
    next_cycle();
    drive(1'b0, mk(32'd0, 7'h0));
    @(negedge Clock);
    check("ar_valid_pre", 64'(bus.OutValid), 64'(1));
    #2;
    Reset = 1'b0;
    #1;
    check("ar_valid", 64'(bus.OutValid), 64'(0));
    check("ar_alu", 64'(bus.OutALUResult), 64'(0));
    check("ar_sd", 64'(bus.OutStoreData), 64'(0));
    check("ar_ctrl", 64'(bus.OutCtrl), 64'(0));
    check("ar_occ", 64'(Occupancy), 64'(0));
    check("ar_ready", 64'(bus.InReady), 64'(1));
    @(negedge Clock);
    Reset = 1'b1;
    next_cycle();

    // InReady response to OutReady within one cycle while an entry is held
    do_reset();
    drive(1'b1, mk(32'h55, 7'h40));
    next_cycle();
    drive(1'b0, mk(32'd0, 7'h0));
    bus.OutReady = 1'b1;
    #1;
    check("rt_ready_a", 64'(bus.InReady), 64'(1));
    bus.OutReady = 1'b0;
    #1;
`ifdef EX_MEM_SKID_EN
    check("rt_ready_b", 64'(bus.InReady), 64'(1));
`else
    check("rt_ready_b", 64'(bus.InReady), 64'(0));
`endif
    bus.OutReady = 1'b1;
    #1;
    check("rt_ready_c", 64'(bus.InReady), 64'(1));
    bus.OutReady = 1'b0;
    next_cycle();

    // Randomized traffic against a FIFO-of-capacity model
    do_reset();
    q.delete();
    for (int c = 0; c < 400; c++) begin
      iv   = ($urandom_range(0, 3) != 0);
      ordy = ($urandom_range(0, 2) != 0);
      fl   = ($urandom_range(0, 31) == 0);
      p    = mk($urandom, 7'($urandom));
      drive(iv, p);
      bus.OutReady = ordy;
      Flush = fl;
      @(negedge Clock);
`ifdef EX_MEM_SKID_EN
      mrdy = (q.size() < 2);
`else
      mrdy = ordy || (q.size() == 0);
`endif
      check("rnd_valid", 64'(bus.OutValid), 64'(q.size() != 0));
      check("rnd_occ", 64'(Occupancy), 64'(q.size()));
      check("rnd_ready", 64'(bus.InReady), 64'(mrdy));
      if (q.size() != 0) begin
        check("rnd_ctrl", 64'(bus.OutCtrl), 64'(q[0].ctrl));
        check("rnd_alu", 64'(bus.OutALUResult), 64'(q[0].alu));
        check("rnd_sd", 64'(bus.OutStoreData), 64'(q[0].sd));
        check("rnd_pc", 64'(bus.OutPCAddResult), 64'(q[0].pc));
        check("rnd_wrz", 64'({bus.OutWriteReg, bus.OutZero}), 64'({q[0].wr, q[0].z}));
      end else begin
        check("rnd_bubble_ctrl", 64'(bus.OutCtrl), 64'(0));
      end
      acc = iv && mrdy;
      drn = (q.size() != 0) && ordy;
      @(posedge Clock);
      if (fl) begin
        q.delete();
      end else begin
        if (drn) void'(q.pop_front());
        if (acc) q.push_back(p);
      end
      #1;
    end
    Flush = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
